// File: rtl/dqsw_delay_trainer.sv
// dqsw_delay_trainer
// Write-leveling sequencer for one DQSW lane IOD. The delay line is swept one
// tap at a time. A single DQS rising edge is launched at each tap, and the
// RX_DATA feedback is sampled. The first stable 0->1 transition is reported on
// TAP_RESULT, and the delay line is left parked on that tap.
//
// Optional feature: define DQSW_TRAINER_EYE_MON_EN to OR the eye-monitor
// EARLY/LATE flags into a per-tap jitter flag. A set flag forces the tap to be
// classified as MIXED. Without the macro, the eye-monitor inputs are ignored.
module dqsw_delay_trainer #(
  parameter int MAX_TAPS      = 128,  // 2..256
  parameter int SETTLE_CYCLES = 16,   // >= 1
  parameter int SAMPLE_CYCLES = 8,    // >= 1
  parameter int MATCH_COUNT   = 2     // 1..8
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic       START,
  input  logic [1:0] RX_DATA,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic [1:0] TX_DATA,
  output logic [1:0] OE_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [7:0] TAP_RESULT
);

  // State encoding
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD    = 4'd1;
  localparam logic [3:0] S_CLEAR   = 4'd2;
  localparam logic [3:0] S_PULSE   = 4'd3;
  localparam logic [3:0] S_SETTLE  = 4'd4;
  localparam logic [3:0] S_SAMPLE  = 4'd5;
  localparam logic [3:0] S_EVAL    = 4'd6;
  localparam logic [3:0] S_MOVE    = 4'd7;
  localparam logic [3:0] S_BACKOFF = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;
  localparam logic [3:0] S_FAIL    = 4'd10;

  // Terminal counts, pre-sized to the registers they are compared against
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYCLES - 1);
  localparam logic [7:0]  TAP_LAST    = 8'(MAX_TAPS - 1);
  localparam logic [3:0]  MATCH_N     = 4'(MATCH_COUNT);
  localparam logic [3:0]  BACK_N      = 4'(MATCH_COUNT - 1);
  localparam logic [7:0]  MATCH_OFS   = 8'(MATCH_COUNT - 1);

  // Control / datapath registers
  logic [3:0]  r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_tap;
  logic        r_seen_zero;
  logic [3:0]  r_ones_run;
  logic [3:0]  r_back_cnt;
  logic        r_all_one;
  logic        r_any_one;
  logic [7:0]  r_tap_result;

  // Registered outputs
  logic       r_load;
  logic       r_move;
  logic       r_dir;
  logic       r_clear;
  logic [1:0] r_tx;
  logic [1:0] r_oe;
  logic       r_busy;
  logic       r_done;
  logic       r_error;

  // Combinational helpers
  logic [3:0] w_state_next;
  logic       w_idle_like;
  logic       w_start_ok;
  logic       w_in_sweep;
  logic       w_jitter;
  logic       w_is_one;
  logic       w_is_zero;
  logic [3:0] w_ones_run_next;
  logic       w_match;

`ifdef DQSW_TRAINER_EYE_MON_EN
  logic r_jitter;
  assign w_jitter = r_jitter;
`else
  logic w_unused_eye;
  assign w_unused_eye = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
  assign w_jitter     = 1'b0;
`endif

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL);
  assign w_start_ok  = w_idle_like && START;
  // LOAD is excluded from the range check: the range flag is still stale from the
  // previous sweep until the load has taken effect.
  assign w_in_sweep  = !w_idle_like && (r_state != S_LOAD);

  // Classify the tap that was just sampled and work out the new ones-run length
  always_comb begin
    w_is_one        = r_all_one && !w_jitter;
    w_is_zero       = !r_any_one && !w_jitter;
    w_ones_run_next = 4'd0;
    if (w_is_one && r_seen_zero) begin
      w_ones_run_next = r_ones_run + 4'd1;
    end
    w_match = (w_ones_run_next == MATCH_N);
  end

  // Next-state logic; an out-of-range flag during the sweep overrides everything
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (START) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD:   w_state_next = S_CLEAR;
      S_CLEAR:  w_state_next = S_PULSE;
      S_PULSE:  w_state_next = S_SETTLE;
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (r_cnt == SAMPLE_LAST) begin
          w_state_next = S_EVAL;
        end
      end
      S_EVAL: begin
        if (w_match) begin
          // With a single-tap match the line is already on the edge tap
          w_state_next = (MATCH_COUNT > 1) ? S_BACKOFF : S_DONE;
        end else if (r_tap == TAP_LAST) begin
          w_state_next = S_FAIL;
        end else begin
          w_state_next = S_MOVE;
        end
      end
      S_MOVE:   w_state_next = S_CLEAR;
      S_BACKOFF: begin
        if (r_back_cnt == 4'd1) begin
          w_state_next = S_DONE;
        end
      end
      default:  w_state_next = S_IDLE;
    endcase
    if (w_in_sweep && DELAY_LINE_OUT_OF_RANGE) begin
      w_state_next = S_FAIL;
    end
  end

  // State register
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Phase counter for SETTLE and SAMPLE; restarts on every state change
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_cnt <= 16'd0;
    end else if (w_state_next != r_state) begin
      r_cnt <= 16'd0;
    end else if ((r_state == S_SETTLE) || (r_state == S_SAMPLE)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Tap index follows the delay line: it steps on the same edge that raises a move
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_tap <= 8'd0;
    end else if (w_start_ok) begin
      r_tap <= 8'd0;
    end else if (w_state_next == S_MOVE) begin
      r_tap <= r_tap + 8'd1;
    end else if (w_state_next == S_BACKOFF) begin
      r_tap <= r_tap - 8'd1;
    end
  end

  // Number of reverse moves still to issue while backing off onto the edge tap
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_back_cnt <= 4'd0;
    end else if ((r_state == S_EVAL) && (w_state_next == S_BACKOFF)) begin
      r_back_cnt <= BACK_N;
    end else if (r_state == S_BACKOFF) begin
      r_back_cnt <= r_back_cnt - 4'd1;
    end
  end

  // Per-tap sample accumulators; they are re-armed during the pulse cycle
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_all_one <= 1'b0;
      r_any_one <= 1'b0;
    end else if (r_state == S_PULSE) begin
      r_all_one <= 1'b1;
      r_any_one <= 1'b0;
    end else if (r_state == S_SAMPLE) begin
      r_all_one <= r_all_one & RX_DATA[0] & RX_DATA[1];
      r_any_one <= r_any_one | RX_DATA[0] | RX_DATA[1];
    end
  end

`ifdef DQSW_TRAINER_EYE_MON_EN
  // Any eye-monitor flag during sampling marks the tap as jittery
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_jitter <= 1'b0;
    end else if (r_state == S_PULSE) begin
      r_jitter <= 1'b0;
    end else if (r_state == S_SAMPLE) begin
      r_jitter <= r_jitter | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
    end
  end
`endif

  // Edge tracking: seen_zero arms the matcher, and ones_run counts confirming taps
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_seen_zero <= 1'b0;
      r_ones_run  <= 4'd0;
    end else if (w_start_ok) begin
      r_seen_zero <= 1'b0;
      r_ones_run  <= 4'd0;
    end else if (r_state == S_EVAL) begin
      r_seen_zero <= r_seen_zero | w_is_zero;
      r_ones_run  <= w_ones_run_next;
    end
  end

  // Result capture: the first tap of the confirming run; kept through FAIL
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_tap_result <= 8'd0;
    end else if ((r_state == S_EVAL) && w_match && (w_state_next != S_FAIL)) begin
      r_tap_result <= r_tap - MATCH_OFS;
    end
  end

  // Output registers decoded from the next state so each strobe lines up with its state
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_load  <= 1'b0;
      r_move  <= 1'b0;
      r_dir   <= 1'b0;
      r_clear <= 1'b0;
      r_tx    <= 2'b00;
      r_oe    <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_load  <= (w_state_next == S_LOAD);
      r_move  <= (w_state_next == S_MOVE) || (w_state_next == S_BACKOFF);
      r_dir   <= (w_state_next == S_MOVE);
      r_clear <= (w_state_next == S_CLEAR);
      r_tx    <= (w_state_next == S_PULSE) ? 2'b01 : 2'b00;
      r_oe    <= (w_state_next == S_PULSE) ? 2'b11 : 2'b00;
      r_busy  <= (w_state_next != S_IDLE) && (w_state_next != S_DONE) &&
                 (w_state_next != S_FAIL);
      r_done  <= (w_state_next == S_DONE);
      r_error <= (w_state_next == S_FAIL);
    end
  end

  assign DELAY_LINE_LOAD         = r_load;
  assign DELAY_LINE_MOVE         = r_move;
  assign DELAY_LINE_DIRECTION    = r_dir;
  assign EYE_MONITOR_CLEAR_FLAGS = r_clear;
  assign TX_DATA                 = r_tx;
  assign OE_DATA                 = r_oe;
  assign BUSY                    = r_busy;
  assign DONE                    = r_done;
  assign ERROR                   = r_error;
  assign TAP_RESULT              = r_tap_result;

endmodule

// File: tb/tb_dqsw_delay_trainer.sv
// Directed testbench for dqsw_delay_trainer. A small IOD/DRAM model follows
// the delay-line strobes and returns the RX_DATA pattern of the current
// scenario for the tap the line is on.
module tb_dqsw_delay_trainer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] rx_data;
  logic       oor;
  logic       early;
  logic       late;
  logic       dl_load;
  logic       dl_move;
  logic       dl_dir;
  logic       em_clear;
  logic [1:0] tx_data;
  logic [1:0] oe_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] tap_result;

  dqsw_delay_trainer #(
    .MAX_TAPS(128), .SETTLE_CYCLES(16), .SAMPLE_CYCLES(8), .MATCH_COUNT(2)
  ) dut (
    .FAB_CLK(clk),
    .ARST(rst),
    .START(start),
    .RX_DATA(rx_data),
    .DELAY_LINE_OUT_OF_RANGE(oor),
    .EYE_MONITOR_EARLY(early),
    .EYE_MONITOR_LATE(late),
    .DELAY_LINE_LOAD(dl_load),
    .DELAY_LINE_MOVE(dl_move),
    .DELAY_LINE_DIRECTION(dl_dir),
    .EYE_MONITOR_CLEAR_FLAGS(em_clear),
    .TX_DATA(tx_data),
    .OE_DATA(oe_data),
    .BUSY(busy),
    .DONE(done),
    .ERROR(error),
    .TAP_RESULT(tap_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Scenario selector and IOD model state (model state written only by the model)
  int mode = 0;
  int pos = 0;
  int cnt = 0;
  int pulses = 0;
  int incs = 0;
  int decs = 0;
  int loads = 0;
  int dir_bad = 0;
  int drive_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // RX feedback per scenario: 0 edge at 20, 1 leading ones, 2/3 glitch at 30, 4 no edge
  function automatic logic [1:0] rx_pattern(input int m, input int p, input int c);
    logic [1:0] v;
    v = 2'b00;
    case (m)
      0: v = (p >= 20) ? 2'b11 : 2'b00;
      1: v = ((p <= 4) || (p >= 10)) ? 2'b11 : 2'b00;
      2, 3: begin
        if (p < 30)                     v = 2'b00;
        else if ((p == 30) && (c == 19)) v = 2'b01;
        else                            v = 2'b11;
      end
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  // IOD/DRAM model, evaluated 1 ns after each rising edge
  initial begin
    rx_data = 2'b00;
    early   = 1'b0;
    late    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (dl_load) begin
        pos = 0;
        loads++;
      end
      if (dl_move) begin
        if (dl_dir) begin
          pos++;
          incs++;
        end else begin
          pos--;
          decs++;
        end
      end
      if (dl_dir && !dl_move) dir_bad++;
      if ((oe_data == 2'b11) && (tx_data == 2'b01)) begin
        pulses++;
        cnt = 0;
      end else begin
        if ((oe_data != 2'b00) || (tx_data != 2'b00)) drive_bad++;
        cnt++;
      end
      rx_data = rx_pattern(mode, pos, cnt);
      early   = (mode == 3) && (pos == 31);
    end
  end

  // One full training run with optional START poke while busy
  task automatic run_sweep(input string name, input int m, input int poke_at,
                           input int exp_done, input int exp_tap, input int exp_pos,
                           input int exp_incs, input int exp_decs, input int exp_pulses,
                           input int exp_cycles);
    int b_incs, b_decs, b_pulses, b_loads, n;
    mode     = m;
    b_incs   = incs;
    b_decs   = decs;
    b_pulses = pulses;
    b_loads  = loads;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_load_pulse"}, int'(dl_load), 1);
    check({name, "_busy_rise"}, int'(busy), 1);
    n = 0;
    while (busy && (n < 20000)) begin
      n++;
      start = (poke_at > 0) && (n == poke_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_busy_cycles"}, n, exp_cycles);
    check({name, "_done"}, int'(done), exp_done);
    check({name, "_error"}, int'(error), 1 - exp_done);
    check({name, "_tap_result"}, int'(tap_result), exp_tap);
    check({name, "_final_pos"}, pos, exp_pos);
    check({name, "_incs"}, incs - b_incs, exp_incs);
    check({name, "_decs"}, decs - b_decs, exp_decs);
    check({name, "_pulses"}, pulses - b_pulses, exp_pulses);
    check({name, "_loads"}, loads - b_loads, 1);
    $display("sweep %s: tap_result=%0d done=%0d error=%0d busy_cycles=%0d pulses=%0d",
             name, tap_result, done, error, n, pulses - b_pulses);
  endtask

  int last_result;
  int n_wait;
  int b_incs_oor;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    oor   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_error", int'(error), 0);
    check("reset_tap_result", int'(tap_result), 0);
    check("reset_strobes", int'({dl_load, dl_move, dl_dir, em_clear, tx_data, oe_data}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Busy cycles = LOAD + 28 per non-final tap + 27 for the final tap + backoff moves
    run_sweep("edge20", 0, 0, 1, 20, 20, 21, 1, 22, 1 + 21*28 + 27 + 1);
    run_sweep("leading_ones", 1, 100, 1, 10, 10, 11, 1, 12, 1 + 11*28 + 27 + 1);
    run_sweep("glitch", 2, 0, 1, 31, 31, 32, 1, 33, 1 + 32*28 + 27 + 1);
    last_result = 31;
`ifdef DQSW_TRAINER_EYE_MON_EN
    run_sweep("eye_early", 3, 0, 1, 32, 32, 33, 1, 34, 1 + 33*28 + 27 + 1);
    last_result = 32;
`endif
    run_sweep("no_edge", 4, 0, 0, last_result, 127, 127, 0, 128, 1 + 127*28 + 27);

    // Out-of-range flag raised in the SETTLE phase of tap 7
    mode = 4;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_wait = 0;
    while (!((pos == 7) && (cnt == 5)) && (n_wait < 2000)) begin
      n_wait++;
      @(negedge clk);
    end
    check("oor_reached_tap7", int'((pos == 7) && (cnt == 5)), 1);
    check("oor_busy_before", int'(busy), 1);
    b_incs_oor = incs;
    oor = 1'b1;
    @(negedge clk);
    check("oor_error_next_cycle", int'(error), 1);
    check("oor_busy_fall", int'(busy), 0);
    check("oor_done", int'(done), 0);
    oor = 1'b0;
    repeat (60) @(negedge clk);
    check("oor_no_moves", incs - b_incs_oor, 0);
    check("oor_pos_held", pos, 7);
    check("oor_tap_result_kept", int'(tap_result), last_result);
    $display("sweep out_of_range: error=%0d busy=%0d pos=%0d", error, busy, pos);

    // Asynchronous reset in the middle of SAMPLE at tap 5
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_wait = 0;
    while (!((pos == 5) && (cnt == 20)) && (n_wait < 2000)) begin
      n_wait++;
      @(negedge clk);
    end
    check("arst_reached_sample", int'((pos == 5) && (cnt == 20)), 1);
    check("arst_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_tap_result", int'(tap_result), 0);
    check("arst_all_outputs", int'({dl_load, dl_move, dl_dir, em_clear, tx_data, oe_data,
                                    busy, done, error, tap_result}), 0);
    $display("async reset mid-sample: busy=%0d tap_result=%0d", busy, tap_result);
    @(negedge clk);
    rst = 1'b0;
    run_sweep("restart_edge20", 0, 0, 1, 20, 20, 21, 1, 22, 1 + 21*28 + 27 + 1);

    check("direction_only_with_move", dir_bad, 0);
    check("dqs_drive_only_in_pulse", drive_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
